// File: rtl/neuron_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed neuron scheduler.
package neuron_pkg;
  localparam int N_DEF            = 32;
  localparam int NUM_NEURONS_DEF  = 16;
  localparam int V_TH_DEF         = 30;
  localparam int V_RESET_DEF      = -65;
  localparam int W_INC_DEF        = 8;
  localparam int REFRAC_STEPS_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Refractory counter width; at least one bit even when refractory is disabled.
  function automatic int rf_width(input int steps);
    return (steps < 1) ? 1 : $clog2(steps + 1);
  endfunction
endpackage

// File: rtl/neuron_state_mem.sv
// Per-neuron v/w/refractory storage: one combinational read port, one write port.
module neuron_state_mem #(
  parameter int N           = 32,
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4,
  parameter int RF_W        = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [N-1:0]     rd_v,
  output logic [N-1:0]     rd_w,
  output logic [RF_W-1:0]  rd_rf,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [N-1:0]     wr_v,
  input  logic [N-1:0]     wr_w,
  input  logic [RF_W-1:0]  wr_rf
);
  logic [NUM_NEURONS-1:0][N-1:0]    v_mem, w_mem;
  logic [NUM_NEURONS-1:0][RF_W-1:0] rf_mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_mem  <= '0;
      w_mem  <= '0;
      rf_mem <= '0;
    end else if (we) begin
      v_mem[wr_idx]  <= wr_v;
      w_mem[wr_idx]  <= wr_w;
      rf_mem[wr_idx] <= wr_rf;
    end
  end

  assign rd_v  = v_mem[rd_idx];
  assign rd_w  = w_mem[rd_idx];
  assign rd_rf = rf_mem[rd_idx];
endmodule

// File: rtl/neuron_scheduler.sv
// Sweeps all virtual neurons through one shared integrator per timestep,
// handling spikes, adaptation increment and refractory skipping.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int NUM_NEURONS  = NUM_NEURONS_DEF,
  parameter int V_TH         = V_TH_DEF,
  parameter int V_RESET      = V_RESET_DEF,
  parameter int W_INC        = W_INC_DEF,
  parameter int REFRAC_STEPS = REFRAC_STEPS_DEF,
  localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_start,
  output logic             busy,
  output logic             step_done,
  output logic             step_overrun,
  output logic [IDX_W-1:0] isyn_idx,
  input  logic [N-1:0]     isyn_data,
  output logic             integ_start,
  output logic [N-1:0]     integ_I,
  output logic [N-1:0]     integ_v,
  output logic [N-1:0]     integ_w,
  input  logic             integ_done,
  input  logic [N-1:0]     integ_v_new,
  input  logic [N-1:0]     integ_w_new,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx
);
  localparam int              RF_W      = rf_width(REFRAC_STEPS);
  localparam logic [N-1:0]    V_TH_X    = N'(V_TH);
  localparam logic [N-1:0]    V_RESET_X = N'(V_RESET);
  localparam logic [N:0]      W_INC_X   = (N+1)'(W_INC);
  localparam logic [RF_W-1:0] REFRAC_X  = RF_W'(REFRAC_STEPS);
  localparam logic [N-1:0]    W_MAX     = {1'b0, {(N-1){1'b1}}};

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic [N-1:0]      lat_i, lat_v, lat_w, v_new_q, w_new_q;
  logic [RF_W-1:0]   lat_rf;
  logic [N-1:0]      rd_v, rd_w, wr_v, wr_w;
  logic [RF_W-1:0]   rd_rf, wr_rf;
  logic              we, last, spike;
  logic [N:0]        w_sum;
  logic [N-1:0]      w_sat;

  neuron_state_mem #(.N(N), .NUM_NEURONS(NUM_NEURONS), .IDX_W(IDX_W), .RF_W(RF_W)) u_mem (
    .clk(clk), .reset_n(reset_n),
    .rd_idx(idx), .rd_v(rd_v), .rd_w(rd_w), .rd_rf(rd_rf),
    .we(we), .wr_idx(idx), .wr_v(wr_v), .wr_w(wr_w), .wr_rf(wr_rf)
  );

  assign last  = (idx == IDX_W'(NUM_NEURONS - 1));
  assign spike = $signed(v_new_q) >= $signed(V_TH_X);
  // Only positive overflow clamps; a negative increment wraps.
  assign w_sum = {w_new_q[N-1], w_new_q} + W_INC_X;
  assign w_sat = (!w_sum[N] && w_sum[N-1]) ? W_MAX : w_sum[N-1:0];

  assign isyn_idx     = idx;
  assign spike_idx    = idx;
  assign integ_I      = lat_i;
  assign integ_v      = lat_v;
  assign integ_w      = lat_w;
  assign step_overrun = step_start & busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      lat_i   <= '0;
      lat_v   <= '0;
      lat_w   <= '0;
      lat_rf  <= '0;
      v_new_q <= '0;
      w_new_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:  if (step_start) idx <= '0;
        S_FETCH: begin
          lat_i  <= isyn_data;
          lat_v  <= rd_v;
          lat_w  <= rd_w;
          lat_rf <= rd_rf;
        end
        S_WAIT:  if (integ_done) begin
          v_new_q <= integ_v_new;
          w_new_q <= integ_w_new;
        end
        S_WB:    if (!last) idx <= idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b1;
    step_done   = 1'b0;
    integ_start = 1'b0;
    spike_valid = 1'b0;
    we          = 1'b0;
    wr_v        = lat_v;
    wr_w        = lat_w;
    wr_rf       = lat_rf;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (step_start) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = (rd_rf != '0) ? S_WB : S_ISSUE;
      S_ISSUE: begin
        integ_start = 1'b1;
        state_nx    = S_WAIT;
      end
      S_WAIT:  if (integ_done) state_nx = S_WB;
      S_WB: begin
        we       = 1'b1;
        state_nx = last ? S_DONE : S_FETCH;
        if (lat_rf != '0) begin
          wr_v  = V_RESET_X;
          wr_rf = lat_rf - RF_W'(1);
        end else if (spike) begin
          spike_valid = 1'b1;
          wr_v        = V_RESET_X;
          wr_w        = w_sat;
          wr_rf       = REFRAC_X;
        end else begin
          wr_v  = v_new_q;
          wr_w  = w_new_q;
          wr_rf = '0;
        end
      end
      S_DONE: begin
        step_done = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 SHALL have parameter N, default 32, meaning the signed two's-complement width of v, w and I.
REQ-002 SHALL have parameter NUM_NEURONS, default 16, meaning the number of virtual neurons time-multiplexed onto one integrator; IDX_W = clog2(NUM_NEURONS).
REQ-003 SHALL have parameters V_TH (default 30), V_RESET (default -65), W_INC (default 8), REFRAC_STEPS (default 2), meaning spike threshold, post-spike v, post-spike w increment, and refractory length in timesteps.
REQ-004 SHALL have the port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have the port reset_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-006 SHALL have the port step_start, input, 1 bit, meaning a request for one timestep update of all neurons.
REQ-007 SHALL have the ports busy and step_done, output, 1 bit each, meaning a sweep is in progress and a 1-cycle sweep-complete pulse.
REQ-008 SHALL have the port step_overrun, output, 1 bit, meaning a 1-cycle pulse when step_start arrives while busy.
REQ-009 SHALL have the ports isyn_idx (output, IDX_W) and isyn_data (input, N), meaning a combinational synaptic-input lookup for the current neuron.
REQ-010 SHALL have the ports integ_start (output, 1), integ_I, integ_v, integ_w (outputs, N), integ_done (input, 1), integ_v_new, integ_w_new (inputs, N), meaning the integrator request/completion handshake.
REQ-011 SHALL have the ports spike_valid (output, 1) and spike_idx (output, IDX_W), meaning a 1-cycle spike event for one neuron.

Function
REQ-012 SHALL implement the FSM states IDLE, FETCH, ISSUE, WAIT, WB, DONE.
REQ-013 IDLE: on step_start=1, SHALL set idx=0 and go to FETCH; busy=1 in every state except IDLE.
REQ-014 FETCH (1 cycle): SHALL drive isyn_idx=idx and latch isyn_data, v[idx], w[idx] and refrac[idx]; go to WB if refrac[idx]!=0, else go to ISSUE.
REQ-015 ISSUE (1 cycle): SHALL assert integ_start=1 with integ_I/v/w set to the latched values; integ_I/v/w SHALL be held stable until integ_done is sampled.
REQ-016 WAIT: SHALL stay in WAIT until integ_done=1 is sampled, then latch integ_v_new/integ_w_new and go to WB; integ_done outside WAIT SHALL be ignored.
REQ-017 WB, refractory path: SHALL write v[idx]=V_RESET, leave w[idx] unchanged, and decrement refrac[idx] by 1.
REQ-018 WB, integrated path: if signed v_new >= V_TH, SHALL pulse spike_valid with spike_idx=idx and write v[idx]=V_RESET, w[idx]=sat(w_new+W_INC), refrac[idx]=REFRAC_STEPS; otherwise SHALL write v[idx]=v_new, w[idx]=w_new.
REQ-019 sat() SHALL clamp to the signed N-bit maximum on positive overflow; no other arithmetic saturates.
REQ-020 WB SHALL go to FETCH with idx+1, or to DONE when idx==NUM_NEURONS-1 (no wrap inside a sweep).
REQ-021 DONE (1 cycle): SHALL pulse step_done=1 and return to IDLE; a step_start in DONE SHALL be treated as overrun.
REQ-022 Cycles per neuron SHALL be 3+L on the integrated path (L = WAIT cycles, L>=1) and 2 on the refractory path.
REQ-023 step_start while busy SHALL pulse step_overrun for 1 cycle, SHALL NOT be queued, and SHALL NOT disturb the sweep.
REQ-024 spike_valid, step_done, step_overrun and integ_start SHALL be 0 in every cycle other than those stated above.

Reset
REQ-025 reset_n=0 SHALL immediately force state=IDLE, idx=0, busy=0, and all pulse outputs, integ_I/v/w, and isyn_idx to 0.
REQ-026 Reset SHALL clear v[], w[] and refrac[] of all neurons to 0, including during a sweep; an integ_done arriving after a mid-sweep reset SHALL be ignored.

Structure
REQ-027 N defaults, FSM state encodings and the V_TH/V_RESET/W_INC/REFRAC_STEPS defaults SHALL live in the shared package neuron_pkg.
REQ-028 The v/w/refrac storage SHALL be one sub-module, neuron_state_mem, with one read port and one write port; the FSM stays in neuron_scheduler.

Verification
REQ-029 NUM_NEURONS=4, isyn_data=0, integrator echoes v/w with L=1, step_start -> 4x4 integrated cycles, then step_done exactly 1 cycle, no spikes.
REQ-030 Integrator returns v_new=30 for idx 2 -> spike_valid with spike_idx=2; v[2]=-65, w[2]=w_new+8; the next 2 sweeps skip the integrator for idx 2 (no integ_start) and the third sweep integrates it.
REQ-031 w_new=0x7FFFFFFC on a spike -> w stored as 0x7FFFFFFF.
REQ-032 step_start asserted during a sweep and in DONE -> one step_overrun pulse each; the sweep completes unchanged, with no extra sweep.
REQ-033 integ_done held low 10 cycles in WAIT -> FSM stays in WAIT with integ_I/v/w stable; a stray integ_done in IDLE has no effect.
REQ-034 reset_n low mid-WAIT on idx 1 -> outputs 0 and state IDLE at once; the late integ_done is ignored; the next sweep sees all v=0.
